// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request stream into a 2-entry in-order
// instruction buffer, with branch redirect and flush of stale in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        PCsrc,
  input  logic [31:0] ImmOp
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_r, state_nx_s;
  logic [31:0] fetch_pc_r, fetch_pc_nx_s;
  logic [1:0]  outstanding_r, outstanding_nx_s;
  logic [1:0]  count_r, count_nx_s;
  logic        head_r, head_nx_s;
  logic [31:0] buf_instr_r [2];
  logic [31:0] buf_pc_r [2];

  logic        pop_s, redirect_s, accept_s, rsp_take_s, push_s, tail_s;
  logic [2:0]  credit_s;
  logic [31:0] rsp_pc_s;

  assign instr_valid = (count_r != 2'd0);
  assign instr       = buf_instr_r[head_r];
  assign instr_pc    = buf_pc_r[head_r];
  assign imem_addr   = fetch_pc_r;

  // Handshake decode, credit check and next-state computation.
  always_comb begin
    state_nx_s    = state_r;
    fetch_pc_nx_s = fetch_pc_r;
    count_nx_s    = count_r;
    head_nx_s     = head_r;

    pop_s      = (state_r == RUN) && instr_valid && instr_ready;
    redirect_s = pop_s && PCsrc;
    // A same-cycle pop frees a slot, which keeps one fetch per cycle in steady state.
    credit_s   = {1'b0, outstanding_r} + {1'b0, count_r} - {2'b00, pop_s};
    imem_req_valid = !rst && (state_r == RUN) && !redirect_s && (credit_s < 3'd2);
    accept_s   = imem_req_valid && imem_req_ready;
    rsp_take_s = imem_rsp_valid && (outstanding_r != 2'd0);
    push_s     = rsp_take_s && (state_r == RUN) && !redirect_s;
    tail_s     = head_r ^ count_r[0];
    // In RUN the outstanding requests are always the contiguous words just below fetch_pc.
    rsp_pc_s   = fetch_pc_r - {28'd0, outstanding_r, 2'b00};
    outstanding_nx_s = outstanding_r + {1'b0, accept_s} - {1'b0, rsp_take_s};

    case (state_r)
      RUN: begin
        if (redirect_s) begin
          fetch_pc_nx_s = (instr_pc + ImmOp) & 32'hFFFF_FFFC;
          count_nx_s    = 2'd0;
          head_nx_s     = 1'b0;
          if (outstanding_nx_s != 2'd0) begin
            state_nx_s = FLUSH;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          if (accept_s) begin
            fetch_pc_nx_s = fetch_pc_r + 32'd4;
          end else begin
            fetch_pc_nx_s = fetch_pc_r;
          end
          count_nx_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
          if (pop_s) begin
            head_nx_s = ~head_r;
          end else begin
            head_nx_s = head_r;
          end
        end
      end
      FLUSH: begin
        if (outstanding_nx_s == 2'd0) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = FLUSH;
        end
      end
      default: begin
        state_nx_s = RUN;
        count_nx_s = 2'd0;
      end
    endcase
  end

  // State, counters and instruction buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= 2'd0;
      count_r       <= 2'd0;
      head_r        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_instr_r[i] <= 32'h0000_0000;
        buf_pc_r[i]    <= 32'h0000_0000;
      end
    end else begin
      state_r       <= state_nx_s;
      fetch_pc_r    <= fetch_pc_nx_s;
      outstanding_r <= outstanding_nx_s;
      count_r       <= count_nx_s;
      head_r        <= head_nx_s;
      if (push_s) begin
        buf_instr_r[tail_s] <= imem_rsp_data;
        buf_pc_r[tail_s]    <= rsp_pc_s;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  out  1  fetch request valid.
REQ-005 imem_req_ready  in  1  instruction memory accepts the request.
REQ-006 imem_addr  out  32  fetch address, word aligned.
REQ-007 imem_rsp_valid  in  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-008 imem_rsp_data  in  32  fetched instruction word.
REQ-009 instr_valid  out  1  instr/instr_pc hold a valid instruction for the decoder.
REQ-010 instr  out  32  instruction to decoder; instr[6:0] is the opcode.
REQ-011 instr_pc  out  32  address of instr.
REQ-012 instr_ready  in  1  decoder consumes instr this cycle.
REQ-013 PCsrc  in  1  decoder branch-taken flag for the presented instr; sampled only on a consume cycle.
REQ-014 ImmOp  in  32  sign-extended branch offset for the presented instr.

Function
REQ-015 Request handshake: a request transfers when imem_req_valid && imem_req_ready; fetch_pc then advances by 4 (mod 2^32).
REQ-016 imem_addr equals fetch_pc; imem_addr[1:0] is always 2'b00.
REQ-017 Once asserted, imem_req_valid and imem_addr hold stable until accepted, except in a redirect cycle, when the request is withdrawn.
REQ-018 A 2-entry in-order buffer holds {instr, pc} pairs; instr_valid = (count != 0); instr/instr_pc present the head entry.
REQ-019 Credit rule: imem_req_valid = (state == RUN) && (outstanding + count < 2); outstanding is 0..2; the buffer never overflows.
REQ-020 Consume: instr_valid && instr_ready pops the head entry.
REQ-021 In RUN, imem_rsp_valid pushes {imem_rsp_data, pc of the oldest outstanding request} and decrements outstanding; push and pop in the same cycle keep count unchanged.
REQ-022 imem_rsp_valid while outstanding == 0 is ignored: no state change.
REQ-023 FSM states: RUN, FLUSH.
REQ-024 Redirect: a consume cycle in RUN with PCsrc == 1.
REQ-025 On redirect, fetch_pc <= (instr_pc + ImmOp) & ~32'h3; the buffer is cleared; any response arriving that cycle is discarded.
REQ-026 On redirect, if outstanding after this cycle's response is non-zero, state <= FLUSH; otherwise state stays RUN.
REQ-027 In FLUSH, imem_req_valid = 0 and instr_valid = 0; each response is discarded and decrements outstanding; when outstanding reaches 0, state <= RUN.
REQ-028 A consume with PCsrc == 0 does not redirect; PCsrc and ImmOp are ignored when no consume occurs.
REQ-029 No combinational path from imem_rsp_* to instr_* (one-cycle response-to-decoder latency); the only combinational input-to-output path is instr_ready to imem_req_valid through the credit rule.

Reset
REQ-030 On rst: fetch_pc = RESET_PC, state = RUN, count = 0, outstanding = 0, instr_valid = 0, instr = 0, instr_pc = 0, imem_req_valid = 0 during the reset cycle.
REQ-031 rst mid-operation (FLUSH, or requests outstanding) discards all state; the memory side is also reset, so no stale responses follow.
REQ-032 The first request, at RESET_PC, is asserted in the first cycle after rst deasserts.

Verification
REQ-033 Straight line: RESET_PC = 0, memory always ready, 1-cycle latency, instr_ready = 1 -> instr_pc sequence 0, 4, 8, 12; after warm-up, one instruction per cycle.
REQ-034 Stall: instr_ready = 0 for 5 cycles -> count reaches 2, imem_req_valid = 0, instr stays at pc 0x8; on release, in-order delivery continues with no loss or duplication.
REQ-035 Taken branch: consume at pc 0x10 with PCsrc = 1 and ImmOp = 32'hFFFF_FFF8 -> next request address 0x08; the 2 in-flight responses are discarded in FLUSH; the next instr_pc is 0x08.
REQ-036 Backpressure: imem_req_ready = 0 for 3 cycles -> imem_addr stays 0x4, then is accepted; no skipped address.
REQ-037 Redirect with outstanding == 0 and ImmOp = 32'h0000_0102 at pc 0x20 -> no FLUSH; next request address 0x120 (misaligned target truncated).
REQ-038 rst asserted in FLUSH -> next cycle: instr_valid = 0, state = RUN, first request at RESET_PC.
